// File: rtl/lfo_bank_sequencer.sv
// lfo_bank_sequencer: NUM_CH LFO channels share one waveform datapath and one sine ROM, swept once per sample tick.
// Optional macro LFO_BANK_SYNC_EN adds sync_in, which zeroes every phase at the next accepted tick.
module lfo_bank_sequencer #(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 2,
   parameter int INC_BASE  = 9739,
   parameter int INC_SCALE = 1894
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            sample_tick,
   input  logic            cfg_wr,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [1:0]      cfg_sel,
   input  logic [9:0]      cfg_data,
   output logic            lut_rd,
   output logic [9:0]      lut_addr,
   input  logic [15:0]     lut_data,
   output logic            out_valid,
   output logic [CH_W-1:0] out_ch,
   output logic [9:0]      out_data,
   output logic            busy,
   output logic            overrun,
   input  logic            overrun_clr
`ifdef LFO_BANK_SYNC_EN
   ,input logic            sync_in
`endif
);
   localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, CAPTURE = 2'd2, EMIT = 2'd3;
   logic [1:0]      state;
   logic [CH_W-1:0] ch;
   logic [31:0]     phase    [NUM_CH];
   logic [1:0]      sh_wave  [NUM_CH];
   logic [1:0]      act_wave [NUM_CH];
   logic [9:0]      sh_freq  [NUM_CH];
   logic [9:0]      act_freq [NUM_CH];
   logic [9:0]      sh_pw    [NUM_CH];
   logic [9:0]      act_pw   [NUM_CH];
   logic            start, sync_go, last, cfg_hit;
   logic [31:0]     p, p_next;
   logic [9:0]      tri_val, wave_val;
   logic            unused_lut_bits;
   assign start           = sample_tick && state == IDLE;
   assign last            = ch == CH_W'(NUM_CH - 1);
   assign cfg_hit         = cfg_wr && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
   assign p               = phase[ch];
   assign busy            = state != IDLE;
   assign lut_rd          = state == FETCH;
   assign out_valid       = state == EMIT;
   assign lut_addr        = p[31:22];
   assign unused_lut_bits = ^lut_data[5:0];
   // waveform of the current channel from its pre-advance phase, and its advanced phase
   always_comb begin
      tri_val  = p[31] ? ~p[30:21] : p[30:21];
      wave_val = act_wave[ch] == 2'd0 ? ((p[31:22] > act_pw[ch]) ? 10'd1023 : 10'd0) :
                 act_wave[ch] == 2'd1 ? tri_val :
                 act_wave[ch] == 2'd2 ? p[31:22] : lut_data[15:6];
      p_next   = p + 32'(INC_BASE) + 32'(act_freq[ch]) * 32'(INC_SCALE);
   end
`ifdef LFO_BANK_SYNC_EN
   logic sync_q;
   assign sync_go = start && (sync_q || sync_in);
   // hold a sync pulse until the next accepted tick consumes it
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= 1'b0;
      else if (start) sync_q <= 1'b0;
      else if (sync_in) sync_q <= 1'b1;
`else
   assign sync_go = 1'b0;
`endif
   // channel sweep: fetch ROM, capture sample into the output register, emit and advance
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= IDLE;
         ch       <= '0;
         out_ch   <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         if (sample_tick && state != IDLE) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
         case (state)
            IDLE:    if (start) state <= FETCH;
            FETCH:   state <= CAPTURE;
            CAPTURE: begin
               state    <= EMIT;
               out_ch   <= ch;
               out_data <= wave_val;
            end
            default: begin
               state <= last ? IDLE : FETCH;
               ch    <= last ? '0 : ch + 1'b1;
            end
         endcase
      end
   // shadow config written any time; copied to active only when a sweep starts
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sh_wave[i]  <= '0;
            sh_freq[i]  <= '0;
            sh_pw[i]    <= '0;
            act_wave[i] <= '0;
            act_freq[i] <= '0;
            act_pw[i]   <= '0;
         end
      end else begin
         if (start)
            for (int i = 0; i < NUM_CH; i++) begin
               act_wave[i] <= sh_wave[i];
               act_freq[i] <= sh_freq[i];
               act_pw[i]   <= sh_pw[i];
            end
         if (cfg_hit)
            case (cfg_sel)
               2'd0:    sh_wave[cfg_ch] <= cfg_data[1:0];
               2'd1:    sh_freq[cfg_ch] <= cfg_data;
               2'd2:    sh_pw[cfg_ch]   <= cfg_data;
               default: ;
            endcase
      end
   // phase accumulators: zeroed by sync at sweep start, advanced after each emit
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
      end else if (sync_go) begin
         for (int i = 0; i < NUM_CH; i++) phase[i] <= '0;
      end else if (state == EMIT) begin
         phase[ch] <= p_next;
      end
endmodule

// File: tb/tb_lfo_bank_sequencer.sv
// tb_lfo_bank_sequencer: randomized bench for lfo_bank_sequencer against a sweep-level reference model.
module tb_lfo_bank_sequencer;
   localparam int N = 4;
`ifdef LFO_BANK_SYNC_EN
   localparam bit SYNC = 1'b1;
   logic sync_in;
`else
   localparam bit SYNC = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset_n, sample_tick, cfg_wr, overrun_clr;
   logic [1:0]  cfg_ch, cfg_sel;
   logic [9:0]  cfg_data;
   logic        lut_rd, out_valid, busy, overrun;
   logic [9:0]  lut_addr, out_data;
   logic [15:0] lut_data;
   logic [1:0]  out_ch;

   int     checks, errors, c, bs, be, last_ch, last_data, prev_addr;
   bit     ov, sl, prev_rd;
   longint ph [N];
   int     sh_w [N], sh_f [N], sh_p [N], ac_w [N], ac_f [N], ac_p [N];
   int     exp_ch [int], exp_data [int], exp_addr [int];
   logic [15:0] rom [1024];

   always #5 clk = ~clk;

   lfo_bank_sequencer dut (
      .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .cfg_wr(cfg_wr),
      .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .lut_rd(lut_rd),
      .lut_addr(lut_addr), .lut_data(lut_data), .out_valid(out_valid), .out_ch(out_ch),
      .out_data(out_data), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef LFO_BANK_SYNC_EN
      , .sync_in(sync_in)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", tag, c, got, exp);
      end
   endtask

   function automatic int wave(input int w, input int pw, input longint p);
      int a, t;
      a = int'(p / 64'd4194304);
      t = int'((p / 64'd2097152) % 1024);
      if (w == 0) return (a > pw) ? 1023 : 0;
      if (w == 1) return (p < 64'd2147483648) ? t : 1023 - t;
      if (w == 2) return a;
      return int'(rom[a]) / 64;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         ph[k] = 0; sh_w[k] = 0; sh_f[k] = 0; sh_p[k] = 0; ac_w[k] = 0; ac_f[k] = 0; ac_p[k] = 0;
      end
      ov = 0; sl = 0; bs = 0; be = -1; last_ch = 0; last_data = 0;
      exp_ch.delete(); exp_data.delete(); exp_addr.delete();
   endtask

   task automatic step(input bit tk, input bit wr, input int ch, input int sel, input int dat,
                       input bit clr, input bit sy, input bit rst);
      bit bz;
      @(posedge clk);
      #1;
      c++;
      chk("busy", busy, (c >= bs && c <= be));
      chk("out_valid", out_valid, exp_ch.exists(c));
      if (exp_ch.exists(c)) begin
         last_ch = exp_ch[c]; last_data = exp_data[c];
         exp_ch.delete(c); exp_data.delete(c);
      end
      chk("out_ch", out_ch, last_ch);
      chk("out_data", out_data, last_data);
      chk("lut_rd", lut_rd, exp_addr.exists(c));
      if (exp_addr.exists(c)) begin
         chk("lut_addr", lut_addr, exp_addr[c]);
         exp_addr.delete(c);
      end
      chk("overrun", overrun, ov);
      lut_data = prev_rd ? rom[prev_addr] : 16'($urandom);
      prev_rd = lut_rd;
      prev_addr = int'(lut_addr);
      sample_tick = 0; cfg_wr = 0; cfg_ch = 0; cfg_sel = 0; cfg_data = 0; overrun_clr = 0;
`ifdef LFO_BANK_SYNC_EN
      sync_in = 0;
`endif
      if (rst) begin
         reset_n = 0;
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_lut_rd", lut_rd, 0);
         chk("rst_lut_addr", lut_addr, 0);
         chk("rst_out_ch", out_ch, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_overrun", overrun, 0);
         model_clear();
         prev_rd = 0;
         reset_n = 1;
         return;
      end
      sample_tick = tk; cfg_wr = wr; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = 10'(dat);
      overrun_clr = clr;
`ifdef LFO_BANK_SYNC_EN
      sync_in = sy;
`endif
      bz = (c >= bs && c <= be);
      if (tk && bz) ov = 1;
      else if (clr) ov = 0;
      if (tk && !bz) begin
         if (SYNC && (sl || sy)) for (int k = 0; k < N; k++) ph[k] = 0;
         sl = 0;
         for (int k = 0; k < N; k++) begin
            ac_w[k] = sh_w[k]; ac_f[k] = sh_f[k]; ac_p[k] = sh_p[k];
            exp_addr[c + 1 + 3 * k] = int'(ph[k] / 64'd4194304);
            exp_ch[c + 3 + 3 * k]   = k;
            exp_data[c + 3 + 3 * k] = wave(ac_w[k], ac_p[k], ph[k]);
            ph[k] = (ph[k] + 9739 + longint'(ac_f[k]) * 1894) % 64'd4294967296;
         end
         bs = c + 1;
         be = c + 3 * N;
      end else if (sy) sl = 1;
      if (wr && ch < N && sel != 3) begin
         if (sel == 0) sh_w[ch] = dat % 4;
         else if (sel == 1) sh_f[ch] = dat;
         else sh_p[ch] = dat;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cfg(input int ch, input int sel, input int dat);
      step(0, 1, ch, sel, dat, 0, 0, 0);
   endtask

   task automatic sweep(input int n, input bit sy);
      repeat (n) begin
         step(1, 0, 0, 0, 0, 0, sy, 0);
         idle(3 * N - 1);
      end
   endtask

   initial begin
      checks = 0; errors = 0; c = 0; prev_rd = 0; prev_addr = 0;
      reset_n = 0; sample_tick = 0; cfg_wr = 0; cfg_ch = 0; cfg_sel = 0; cfg_data = 0;
      overrun_clr = 0; lut_data = 0;
`ifdef LFO_BANK_SYNC_EN
      sync_in = 0;
`endif
      for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
      rom[0] = 16'hFFC0;
      rom[1] = 16'h003F;
      model_clear();
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      cfg(0, 0, 2); cfg(0, 1, 1023);
      sweep(4, 0);
      cfg(0, 0, 1);
      sweep(4, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      cfg(0, 0, 3);
      sweep(2, 0);
      cfg(0, 0, 0); cfg(0, 2, 0); cfg(0, 1, 1023);
      sweep(4, 0);
      cfg(0, 2, 1023);
      sweep(3, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(8);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      idle(2);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      cfg(1, 1, 1023);
      idle(11);
      step(1, 1, 2, 1, 1023, 0, 0, 0);
      idle(12);
      sweep(2, 0);
      cfg(3, 3, 777);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(5);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 15) == 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 799) == 0);
      idle(3 * N + 2);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < N; k++) begin
         cfg(k, 0, 2); cfg(k, 1, 1023);
      end
      sweep(2210, 0);
      for (int k = 0; k < N; k++) cfg(k, 0, k);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      sweep(2, 0);
      sweep(1, 1);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
